// File: rtl/latch_fifo.sv
// rtl/latch_fifo.sv - latch-array FIFO with flop pointers; LATCH_FIFO_ERR_EN enables the sticky ERR flag
// Latches open while CLK is low for the entry written at the preceding rising edge.
module latch_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       CLK,
   input  logic                       RSTB,
   input  logic                       WR_EN,
   input  logic [WIDTH-1:0]           D,
   output logic                       FULL,
   input  logic                       RD_EN,
   output logic [WIDTH-1:0]           Q,
   output logic                       EMPTY,
   output logic [$clog2(DEPTH+1)-1:0] COUNT,
   output logic                       ERR
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    pend_ptr;
   logic [CW-1:0]    occ;
   logic             pend;
   logic [WIDTH-1:0] wdata;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] mem_rd [DEPTH];

   assign FULL  = (occ == CW'(DEPTH));
   assign COUNT = occ - CW'(pend);
   assign EMPTY = (COUNT == '0);
   assign push  = WR_EN & ~FULL;
   assign pop   = RD_EN & ~EMPTY;

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         pend_ptr <= '0;
         occ      <= '0;
         pend     <= 1'b0;
         wdata    <= '0;
      end else begin
         // A new push keeps pend high; the previous write retires at this same edge.
         if (push) begin
            wdata    <= D;
            pend_ptr <= wr_ptr;
            wr_ptr   <= wr_ptr + PW'(1);
            pend     <= 1'b1;
         end else begin
            pend     <= 1'b0;
         end
         if (pop) begin
            rd_ptr   <= rd_ptr + PW'(1);
         end
         occ <= occ + CW'(push) - CW'(pop);
      end
   end

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      logic             lat_en;
      logic [WIDTH-1:0] word;

      // Gating by CLK low closes the latch before wdata/pend_ptr change at the rising edge.
      assign lat_en = ~CLK & pend & (pend_ptr == PW'(i));

      always_latch begin
         if (lat_en) begin
            word <= wdata;
         end
      end

      assign mem_rd[i] = word;
   end

   assign Q = EMPTY ? '0 : mem_rd[rd_ptr];

`ifdef LATCH_FIFO_ERR_EN
   logic err_q;

   always_ff @(posedge CLK or negedge RSTB) begin
      if (!RSTB) begin
         err_q <= 1'b0;
      end else if ((WR_EN & FULL) | (RD_EN & EMPTY)) begin
         err_q <= 1'b1;
      end
   end

   assign ERR = err_q;
`else
   assign ERR = 1'b0;
`endif

endmodule
